// File: rtl/lc3_mem_responder_if.sv
// lc3_mem_responder_if
//   Memory-port bundle between the LC3 core and its memory responder.
//   master : the core side (drives request, address, write data)
//   slave  : the responder side (drives read data and status)
//   memEN/memWE/memory_addr/memory_din : request, held until memRDY
//   memory_dout/memRDY/busy/addr_err   : response and status
interface lc3_mem_responder_if;
  logic        memEN;
  logic        memWE;
  logic [15:0] memory_addr;
  logic [15:0] memory_din;
  logic [15:0] memory_dout;
  logic        memRDY;
  logic        busy;
  logic        addr_err;

  modport master (
    output memEN, memWE, memory_addr, memory_din,
    input  memory_dout, memRDY, busy, addr_err
  );

  modport slave (
    input  memEN, memWE, memory_addr, memory_din,
    output memory_dout, memRDY, busy, addr_err
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
//   Memory-side responder for the LC3 memory port. Word-addressed RAM with a
//   fixed number of wait states per access and a one-cycle memRDY pulse on
//   completion. A backdoor port allows program preload on any clock edge.
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   mem_if   : core handshake bundle (slave side)
//   ld_en    : backdoor write strobe
//   ld_addr  : backdoor word address
//   ld_data  : backdoor write data
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for memEN; request fields latched on the sampling edge
// WAIT   | counting down wait states; memEN low here aborts the access
// RESP   | access committed on the entry edge; memRDY high this cycle
module lc3_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2,
  parameter int STRICT      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  lc3_mem_responder_if.slave    mem_if,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [15:0]           ld_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        we_q, we_d;
  logic [15:0] dout_q, dout_d;
  logic        err_q, err_d;

  logic [15:0] mem [DEPTH];

  logic [15:0]           acc_addr;
  logic [15:0]           acc_din;
  logic                  acc_we;
  logic                  acc_oor;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  enter_resp;
  logic                  commit_wr;

  // With zero wait states the access commits on the sampling edge itself,
  // before the latched copies exist, so IDLE uses the live bus fields.
  always_comb begin
    acc_addr = addr_q;
    acc_din  = din_q;
    acc_we   = we_q;
    if (state_q == S_IDLE) begin
      acc_addr = mem_if.memory_addr;
      acc_din  = mem_if.memory_din;
      acc_we   = mem_if.memWE;
    end
    acc_oor = (STRICT != 0) && ((acc_addr >> DEPTH_LOG2) != 16'h0000);
    acc_idx = acc_addr[DEPTH_LOG2-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      din_q   <= 16'h0000;
      we_q    <= 1'b0;
      dout_q  <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = we_q;
    case (state_q)
      S_IDLE: begin
        if (mem_if.memEN) begin
          addr_d = mem_if.memory_addr;
          din_d  = mem_if.memory_din;
          we_d   = mem_if.memWE;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_M1;
          end
        end
      end
      S_WAIT: begin
        if (!mem_if.memEN) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    // rst gating keeps a zero-wait-state write from landing while held in reset.
    commit_wr  = rst && enter_resp && acc_we && !acc_oor;
    err_d      = enter_resp && acc_oor;
    dout_d     = dout_q;
    if (enter_resp && !acc_we) begin
      dout_d = acc_oor ? 16'h0000 : mem[acc_idx];
    end
  end

  always_comb begin
    mem_if.memRDY      = (state_q == S_RESP);
    mem_if.busy        = (state_q != S_IDLE);
    mem_if.addr_err    = (state_q == S_RESP) && err_q;
    mem_if.memory_dout = dout_q;
  end

  // Core write is placed after the backdoor write so it wins on a collision;
  // reads sample mem before either update, returning the old word.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
    if (commit_wr) begin
      mem[acc_idx] <= acc_din;
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
module tb_lc3_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic       ld_en_a, ld_en_b;
  logic [9:0] ld_addr_a, ld_addr_b;
  logic [15:0] ld_data_a, ld_data_b;

  lc3_mem_responder_if bus_a ();
  lc3_mem_responder_if bus_b ();

  lc3_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2), .STRICT(1)) dut_a (
    .clk(clk), .rst(rst), .mem_if(bus_a),
    .ld_en(ld_en_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a)
  );

  lc3_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0), .STRICT(0)) dut_b (
    .clk(clk), .rst(rst), .mem_if(bus_b),
    .ld_en(ld_en_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b)
  );

  typedef struct {
    bit          we;
    logic [15:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_mem [int];
  logic [15:0] last_dout [2];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? bus_a.memRDY : bus_b.memRDY;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus_a.busy : bus_b.busy;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus_a.addr_err : bus_b.addr_err;
  endfunction
  function automatic logic [15:0] get_dout(input int sel);
    return (sel == 0) ? bus_a.memory_dout : bus_b.memory_dout;
  endfunction

  task automatic set_req(input int sel, input bit en, input bit we,
                         input logic [15:0] addr, input logic [15:0] din);
    if (sel == 0) begin
      bus_a.memEN = en; bus_a.memWE = we; bus_a.memory_addr = addr; bus_a.memory_din = din;
    end else begin
      bus_b.memEN = en; bus_b.memWE = we; bus_b.memory_addr = addr; bus_b.memory_din = din;
    end
  endtask

  task automatic backdoor(input int sel, input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    if (sel == 0) begin ld_en_a = 1'b1; ld_addr_a = a; ld_data_a = d; end
    else          begin ld_en_b = 1'b1; ld_addr_b = a; ld_data_b = d; end
    model_mem[sel * 65536 + int'(a)] = d;
    @(negedge clk);
    ld_en_a = 1'b0;
    ld_en_b = 1'b0;
  endtask

  // Computes the expected response from the bench's own memory model, then drives.
  task automatic issue(input int sel, input bit we, input logic [15:0] addr, input logic [15:0] din);
    exp_t e;
    bit   oor;
    int   key;
    oor = (sel == 0) && (addr[15:10] != 6'd0);
    key = sel * 65536 + int'(addr[9:0]);
    e.we  = we;
    e.err = oor;
    if (we) begin
      if (!oor) model_mem[key] = din;
      e.data = last_dout[sel];
    end else begin
      if (oor)                      e.data = 16'h0000;
      else if (model_mem.exists(key)) e.data = model_mem[key];
      else                          e.data = 16'hxxxx;
      last_dout[sel] = e.data;
    end
    sb.push_back(e);
    set_req(sel, 1'b1, we, addr, din);
  endtask

  task automatic compare_resp(input int sel, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " dout"}, get_dout(sel), e.data);
      check({tag, " addr_err"}, get_err(sel), e.err);
    end
  endtask

  task automatic wait_done(input int sel, input string tag, input int exp_lat,
                           output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (get_busy(sel)) busy_n++;
    end while (!get_rdy(sel) && lat < 40);
    check({tag, " latency"}, lat, exp_lat);
    compare_resp(sel, tag);
  endtask

  task automatic release_req(input int sel, input string tag);
    @(negedge clk);
    set_req(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    check({tag, " memRDY one cycle"}, get_rdy(sel), 1'b0);
    check({tag, " busy after"}, get_busy(sel), 1'b0);
  endtask

  task automatic simple(input int sel, input string tag, input bit we,
                        input logic [15:0] addr, input logic [15:0] din, input int exp_lat);
    int lat, bn;
    @(negedge clk);
    issue(sel, we, addr, din);
    wait_done(sel, tag, exp_lat, lat, bn);
    release_req(sel, tag);
  endtask

  // Core access on dut_a with a backdoor write to ld_a landing on the commit edge.
  task automatic collide(input string tag, input bit we, input logic [15:0] addr,
                         input logic [15:0] din, input logic [15:0] ld_d);
    @(negedge clk);
    issue(0, we, addr, din);
    if (!we) model_mem[int'(addr[9:0])] = ld_d;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    ld_en_a = 1'b1; ld_addr_a = addr[9:0]; ld_data_a = ld_d;
    @(posedge clk); #1;
    check({tag, " memRDY"}, get_rdy(0), 1'b1);
    compare_resp(0, tag);
    @(negedge clk);
    ld_en_a = 1'b0;
    set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    check({tag, " busy after"}, get_busy(0), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bn, total, rdy_seen;

    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    ld_en_a = 1'b0; ld_addr_a = '0; ld_data_a = '0;
    ld_en_b = 1'b0; ld_addr_b = '0; ld_data_b = '0;
    last_dout[0] = 16'h0000;
    last_dout[1] = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("reset memRDY", bus_a.memRDY, 1'b0);
    check("reset busy", bus_a.busy, 1'b0);
    check("reset addr_err", bus_a.addr_err, 1'b0);
    check("reset dout a", bus_a.memory_dout, 16'h0000);
    check("reset dout b", bus_b.memory_dout, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Preloaded read with two wait states: three busy cycles ending in memRDY.
    backdoor(0, 10'h005, 16'h1234);
    @(negedge clk);
    issue(0, 1'b0, 16'h0005, 16'h0000);
    wait_done(0, "t1 read", 3, lat, bn);
    check("t1 busy cycles", bn, 3);
    release_req(0, "t1");

    // Write then read back-to-back with memEN held throughout.
    @(negedge clk);
    issue(0, 1'b1, 16'h0010, 16'hBEEF);
    wait_done(0, "t2 write", 3, lat, bn);
    @(negedge clk);
    issue(0, 1'b0, 16'h0010, 16'h0000);
    wait_done(0, "t2 b2b read", 4, lat, bn);
    release_req(0, "t2");

    // Zero wait states: single read, then a held 10-access stream.
    backdoor(1, 10'h000, 16'h0CAB);
    simple(1, "t3 read", 1'b0, 16'h0000, 16'h0000, 1);
    total = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(1, (i % 2) == 0, 16'h0100 + 16'(i / 2), 16'hA000 + 16'(i));
      wait_done(1, "t3 stream", (i == 0) ? 1 : 2, lat, bn);
      total += lat;
    end
    check("t3 stream total", total, 19);
    release_req(1, "t3");

    // Out-of-range write: flagged and dropped in strict mode, aliased otherwise.
    backdoor(0, 10'h000, 16'h1111);
    simple(0, "t4 oor write", 1'b1, 16'h0400, 16'h5555, 3);
    simple(0, "t4 read 0", 1'b0, 16'h0000, 16'h0000, 3);
    simple(0, "t4 oor read", 1'b0, 16'h0400, 16'h0000, 3);
    simple(1, "t4 alias write", 1'b1, 16'h0400, 16'h5555, 1);
    simple(1, "t4 alias read 0", 1'b0, 16'h0000, 16'h0000, 1);

    // Reset during the wait of a write: outputs drop at once, no write lands.
    backdoor(0, 10'h020, 16'h0001);
    set_req(0, 1'b1, 1'b1, 16'h0020, 16'hDEAD);
    @(posedge clk); #1;
    check("t5 busy in wait", bus_a.busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("t5 busy async drop", bus_a.busy, 1'b0);
    check("t5 memRDY async", bus_a.memRDY, 1'b0);
    check("t5 dout reset", bus_a.memory_dout, 16'h0000);
    last_dout[0] = 16'h0000;
    set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    simple(0, "t5 read 0x20", 1'b0, 16'h0020, 16'h0000, 3);

    // Same-edge collisions between core commit and backdoor write.
    collide("t6 write collide", 1'b1, 16'h0030, 16'hAAAA, 16'h7777);
    simple(0, "t6 read 0x30", 1'b0, 16'h0030, 16'h0000, 3);
    backdoor(0, 10'h031, 16'h1357);
    collide("t6 read collide", 1'b0, 16'h0031, 16'h0000, 16'h2468);
    simple(0, "t6 read 0x31", 1'b0, 16'h0031, 16'h0000, 3);

    // memEN dropped mid-wait on a write: no memRDY, no write, back to idle.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 16'h0005, 16'hFFFF);
    @(posedge clk); #1;
    check("t6 abort busy", bus_a.busy, 1'b1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rdy_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus_a.memRDY) rdy_seen++;
    end
    check("t6 abort no memRDY", rdy_seen, 0);
    check("t6 abort idle", bus_a.busy, 1'b0);
    simple(0, "t6 read after abort", 1'b0, 16'h0005, 16'h0000, 3);

    check("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
